// File: rtl/crack_scheduler.sv
// crack_scheduler: splits the leading-character keyspace into chunks, hands one
// chunk per cycle to the lowest idle cracker engine, collects done/found and
// aborts the pool on the first hit.
// Optional watchdog: define CRACK_TIMEOUT_EN to build the per-job cycle limit.
module crack_scheduler #(
    parameter int unsigned NUM_ENGINES    = 4,
    parameter int unsigned RANGE_W        = 6,
    parameter int unsigned KEYSPACE       = 36,
    parameter int unsigned CHUNK          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [15:0]                    password_in,
    output logic                           busy,
    output logic                           done,
    output logic                           found,
    output logic [2:0]                     found_engine,
    output logic [RANGE_W-1:0]             found_from,
    output logic                           timeout,
    output logic [15:0]                    eng_password,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [NUM_ENGINES*RANGE_W-1:0] eng_from,
    output logic [NUM_ENGINES*RANGE_W-1:0] eng_to,
    output logic [NUM_ENGINES-1:0]         eng_abort,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    input  logic [NUM_ENGINES-1:0]         eng_found
);

    // One extra bit so next_from can step past the last symbol without wrapping.
    localparam int unsigned   NW         = RANGE_W + 1;
    localparam logic [NW-1:0] LAST_IDX   = NW'(KEYSPACE - 1);
    localparam logic [NW-1:0] CHUNK_INC  = NW'(CHUNK);
    localparam logic [NW-1:0] CHUNK_SPAN = NW'(CHUNK - 1);

    if (NUM_ENGINES == 0 || NUM_ENGINES > 8 || CHUNK == 0 || CHUNK > KEYSPACE ||
        KEYSPACE > (1 << RANGE_W) || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535)
    begin : g_param_check
        $error("crack_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StDispatch, StWait, StFinish} state_t;

    state_t                 state;
    logic [NUM_ENGINES-1:0] eng_busy;
    logic [NW-1:0]          next_from;
    logic                   hit_seen;

    logic [NUM_ENGINES-1:0] sel_onehot;
    logic                   sel_valid;
    logic [NUM_ENGINES-1:0] hit_onehot;
    logic                   hit_valid;
    logic [2:0]             hit_idx;
    logic [RANGE_W-1:0]     hit_from;
    logic [NUM_ENGINES-1:0] busy_after_done;
    logic [NW-1:0]          next_adv;
    logic [NW-1:0]          chunk_last;
    logic                   expired;

    // Lowest idle engine, lowest-index winner and bounds of the next chunk.
    always_comb begin
        sel_onehot = '0;
        sel_valid  = 1'b0;
        hit_onehot = '0;
        hit_valid  = 1'b0;
        hit_idx    = '0;
        hit_from   = '0;
        // Descending scan so the lowest index is the one left standing.
        for (int i = int'(NUM_ENGINES) - 1; i >= 0; i--) begin
            if (!eng_busy[i]) begin
                sel_valid     = 1'b1;
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
            if (eng_busy[i] && eng_done[i] && eng_found[i]) begin
                hit_valid     = 1'b1;
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
                hit_idx       = 3'(i);
                hit_from      = eng_from[i*RANGE_W +: RANGE_W];
            end
        end
        busy_after_done = eng_busy & ~eng_done;
        next_adv        = next_from + CHUNK_INC;
        chunk_last      = next_from + CHUNK_SPAN;
        if (chunk_last > LAST_IDX) chunk_last = LAST_IDX;
    end

`ifdef CRACK_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    assign expired = (tmo_cnt + 16'd1) == 16'(TIMEOUT_CYCLES);

    // Watchdog: cleared on an accepted start, counts every busy cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == StIdle && start) begin
            tmo_cnt <= '0;
        end else if (busy) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign expired = 1'b0;
`endif

    // Job sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            busy         <= 1'b0;
            done         <= 1'b0;
            found        <= 1'b0;
            found_engine <= '0;
            found_from   <= '0;
            timeout      <= 1'b0;
            eng_password <= '0;
            eng_start    <= '0;
            eng_from     <= '0;
            eng_to       <= '0;
            eng_abort    <= '0;
            eng_busy     <= '0;
            next_from    <= '0;
            hit_seen     <= 1'b0;
        end else begin
            eng_start <= '0;
            eng_abort <= '0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        eng_password <= password_in;
                        done         <= 1'b0;
                        found        <= 1'b0;
                        timeout      <= 1'b0;
                        hit_seen     <= 1'b0;
                        next_from    <= '0;
                        busy         <= 1'b1;
                        state        <= StDispatch;
                    end
                end
                StDispatch, StWait: begin
                    if (hit_valid) begin
                        // A hit beats a same-cycle watchdog expiry.
                        found_engine <= hit_idx;
                        found_from   <= hit_from;
                        eng_abort    <= eng_busy & ~hit_onehot;
                        eng_busy     <= '0;
                        hit_seen     <= 1'b1;
                        state        <= StFinish;
                    end else if (expired) begin
                        eng_abort <= eng_busy;
                        eng_busy  <= '0;
                        timeout   <= 1'b1;
                        state     <= StFinish;
                    end else if (state == StDispatch) begin
                        if (sel_valid && next_from <= LAST_IDX) begin
                            for (int i = 0; i < int'(NUM_ENGINES); i++) begin
                                if (sel_onehot[i]) begin
                                    eng_from[i*RANGE_W +: RANGE_W] <= next_from[RANGE_W-1:0];
                                    eng_to[i*RANGE_W +: RANGE_W]   <= chunk_last[RANGE_W-1:0];
                                end
                            end
                            eng_start <= sel_onehot;
                            eng_busy  <= busy_after_done | sel_onehot;
                            next_from <= next_adv;
                            if (next_adv > LAST_IDX) state <= StWait;
                        end else begin
                            eng_busy <= busy_after_done;
                            if (next_from > LAST_IDX) state <= StWait;
                        end
                    end else begin
                        eng_busy <= busy_after_done;
                        if (eng_busy == '0) state <= StFinish;
                    end
                end
                StFinish: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    found <= hit_seen;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_crack_scheduler.sv
// Bench for crack_scheduler: stub engines, a transaction-level model of the
// scheduling rules, a per-cycle compare and a few literal scenario checks.
module tb_crack_scheduler;

    localparam int NE         = 4;
    localparam int RW         = 6;
    localparam int KS         = 36;
    localparam int CH         = 8;
    localparam int TB_TIMEOUT = 50;
    localparam int NCHUNK     = (KS + CH - 1) / CH;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [15:0]       password_in;
    logic              busy, done, found, timeout;
    logic [2:0]        found_engine;
    logic [RW-1:0]     found_from;
    logic [15:0]       eng_password;
    logic [NE-1:0]     eng_start, eng_abort, eng_done, eng_found;
    logic [NE*RW-1:0]  eng_from, eng_to;

    always #5 clk = ~clk;

    crack_scheduler #(
        .NUM_ENGINES(NE), .RANGE_W(RW), .KEYSPACE(KS), .CHUNK(CH),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .password_in(password_in),
        .busy(busy), .done(done), .found(found), .found_engine(found_engine),
        .found_from(found_from), .timeout(timeout), .eng_password(eng_password),
        .eng_start(eng_start), .eng_from(eng_from), .eng_to(eng_to),
        .eng_abort(eng_abort), .eng_done(eng_done), .eng_found(eng_found)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int start_cyc = 0;

    // Model state
    bit          m_busy, m_done, m_found, m_timeout, m_hit, m_fin;
    int          m_fe, m_ff, m_issued, m_cyc;
    logic [15:0] m_pw;
    int          m_from[NE];
    int          m_to[NE];
    bit          m_eb[NE];
    logic [NE-1:0] exp_start, exp_abort;

    // Stub engines
    int        tmr[NE];
    bit        fnd[NE];
    int        lat[NE];
    bit [63:0] hit_mask;
    bit        spurious;

    // Logs for literal checks
    int            log_eng[$];
    int            log_from[$];
    int            log_to[$];
    logic [NE-1:0] last_abort;
    int            abort_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_found = 0; m_timeout = 0; m_hit = 0; m_fin = 0;
        m_fe = 0; m_ff = 0; m_issued = 0; m_cyc = 0; m_pw = '0;
        for (int i = 0; i < NE; i++) begin
            m_from[i] = 0; m_to[i] = 0; m_eb[i] = 0;
        end
    endtask

    // One collection/dispatch cycle of an active job.
    task automatic collect();
        int win;
        int pick;
        bit any_busy;
        bit old_eb[NE];
        win = -1;
        for (int i = 0; i < NE; i++)
            if (win < 0 && m_eb[i] && eng_done[i] && eng_found[i]) win = i;
        if (win >= 0) begin
            m_fe = win;
            m_ff = m_from[win];
            for (int i = 0; i < NE; i++) begin
                exp_abort[i] = m_eb[i] && (i != win);
                m_eb[i] = 0;
            end
            m_hit = 1;
            m_fin = 1;
        end
`ifdef CRACK_TIMEOUT_EN
        else if (m_cyc + 1 == TB_TIMEOUT) begin
            for (int i = 0; i < NE; i++) begin
                exp_abort[i] = m_eb[i];
                m_eb[i] = 0;
            end
            m_timeout = 1;
            m_fin = 1;
        end
`endif
        else begin
            old_eb = m_eb;
            any_busy = 0;
            for (int i = 0; i < NE; i++) begin
                if (old_eb[i]) any_busy = 1;
                if (eng_done[i]) m_eb[i] = 0;
            end
            if (m_issued < NCHUNK) begin
                pick = -1;
                for (int i = NE - 1; i >= 0; i--) if (!old_eb[i]) pick = i;
                if (pick >= 0) begin
                    m_from[pick] = m_issued * CH;
                    m_to[pick] = (m_from[pick] + CH - 1 > KS - 1) ? KS - 1 : m_from[pick] + CH - 1;
                    m_eb[pick] = 1;
                    exp_start[pick] = 1'b1;
                    m_issued++;
                end
            end else if (!any_busy) begin
                m_fin = 1;
            end
        end
    endtask

    // Predict the next edge, clock it, compare, then let the stubs react.
    task automatic step();
        bit was_busy;
        logic [NE*RW-1:0] ef, et;
        was_busy = m_busy;
        exp_start = '0;
        exp_abort = '0;
        if (rst) begin
            model_reset();
        end else if (m_fin) begin
            m_fin = 0; m_done = 1; m_busy = 0; m_found = m_hit;
        end else if (!m_busy) begin
            if (start) begin
                m_pw = password_in; m_busy = 1; m_done = 0; m_found = 0;
                m_timeout = 0; m_hit = 0; m_issued = 0; m_cyc = 0;
            end
        end else begin
            collect();
        end
        if (!rst && was_busy) m_cyc++;
        for (int i = 0; i < NE; i++) begin
            ef[i*RW +: RW] = RW'(m_from[i]);
            et[i*RW +: RW] = RW'(m_to[i]);
        end

        @(posedge clk);
        #1;
        cyc++;
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("found", 64'(found), 64'(m_found));
        chk("timeout", 64'(timeout), 64'(m_timeout));
        chk("found_engine", 64'(found_engine), 64'(m_fe));
        chk("found_from", 64'(found_from), 64'(m_ff));
        chk("eng_password", 64'(eng_password), 64'(m_pw));
        chk("eng_start", 64'(eng_start), 64'(exp_start));
        chk("eng_abort", 64'(eng_abort), 64'(exp_abort));
        chk("eng_from", 64'(eng_from), 64'(ef));
        chk("eng_to", 64'(eng_to), 64'(et));

        for (int i = 0; i < NE; i++) begin
            if (eng_start[i]) begin
                log_eng.push_back(i);
                log_from.push_back(int'(eng_from[i*RW +: RW]));
                log_to.push_back(int'(eng_to[i*RW +: RW]));
            end
        end
        if (eng_abort != '0) begin
            last_abort = eng_abort;
            abort_cyc = cyc;
        end

        for (int i = 0; i < NE; i++) begin
            if (rst || eng_abort[i]) tmr[i] = -1;
            if (eng_start[i]) begin
                tmr[i] = lat[i];
                fnd[i] = hit_mask[eng_from[i*RW +: RW]];
            end
            eng_done[i] = 1'b0;
            eng_found[i] = 1'b0;
            if (tmr[i] > 0) begin
                tmr[i]--;
                if (tmr[i] == 0) begin
                    eng_done[i] = 1'b1;
                    eng_found[i] = fnd[i];
                    tmr[i] = -1;
                end
            end else if (tmr[i] < 0 && spurious && $urandom_range(0, 15) == 0) begin
                eng_done[i] = 1'b1;
                eng_found[i] = 1'($urandom);
            end
        end
    endtask

    task automatic pulse_start(input logic [15:0] pw);
        start = 1'b1;
        password_in = pw;
        step();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic run_to_done(input int limit, input bit noisy);
        int n;
        n = 0;
        while (!m_done && n < limit) begin
            if (noisy) begin
                start = ($urandom_range(0, 15) == 0);
                password_in = 16'($urandom);
            end
            step();
            n++;
        end
        start = 1'b0;
        if (!m_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL job_bound: no done within %0d cycles", limit);
        end
    endtask

    task automatic clear_logs();
        log_eng.delete();
        log_from.delete();
        log_to.delete();
        last_abort = '0;
        abort_cyc = 0;
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    endtask

    int exp_e[5] = '{0, 1, 2, 3, 0};
    int exp_f[5] = '{0, 8, 16, 24, 32};
    int exp_t[5] = '{7, 15, 23, 31, 35};

    initial begin
        model_reset();
        for (int i = 0; i < NE; i++) begin
            tmr[i] = -1; fnd[i] = 0; lat[i] = 10;
        end
        hit_mask = '0;
        spurious = 0;
        rst = 1'b1; start = 1'b0; password_in = '0; eng_done = '0; eng_found = '0;
        clear_logs();

        // Reset then idle
        repeat (3) step();
        rst = 1'b0;
        clear_logs();
        repeat (20) step();
        chk("idle_starts", 64'(log_eng.size()), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);

        // Full sweep, no hit
        set_lat(10, 10, 10, 10);
        clear_logs();
        pulse_start(16'h4142);
        run_to_done(500, 0);
        chk("sweep_n", 64'(log_eng.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < log_eng.size()) begin
                chk("sweep_eng", 64'(log_eng[k]), 64'(exp_e[k]));
                chk("sweep_from", 64'(log_from[k]), 64'(exp_f[k]));
                chk("sweep_to", 64'(log_to[k]), 64'(exp_t[k]));
            end
        end
        chk("sweep_latency", 64'(cyc - start_cyc), 64'd24);
        chk("sweep_done", 64'(done), 64'd1);
        chk("sweep_found", 64'(found), 64'd0);
        chk("sweep_busy", 64'(busy), 64'd0);

        // Hit mid-job on engine 2
        set_lat(20, 20, 5, 20);
        hit_mask = '0;
        hit_mask[16] = 1'b1;
        clear_logs();
        pulse_start(16'h3739);
        run_to_done(500, 0);
        chk("hit_abort", 64'(last_abort), 64'(4'b1011));
        chk("hit_engine", 64'(found_engine), 64'd2);
        chk("hit_from", 64'(found_from), 64'd16);
        chk("hit_found", 64'(found), 64'd1);
        chk("hit_done", 64'(done), 64'd1);
        repeat (20) step();
        chk("hit_nstarts", 64'(log_eng.size()), 64'd4);

        // Simultaneous hits on engines 1 and 3
        set_lat(20, 7, 20, 5);
        hit_mask = '0;
        hit_mask[8] = 1'b1;
        hit_mask[24] = 1'b1;
        clear_logs();
        pulse_start(16'h4B4C);
        run_to_done(500, 0);
        chk("sim_engine", 64'(found_engine), 64'd1);
        chk("sim_from", 64'(found_from), 64'd8);
        chk("sim_abort", 64'(last_abort), 64'(4'b1101));

        // Start while waiting is ignored
        set_lat(10, 10, 10, 10);
        hit_mask = '0;
        clear_logs();
        pulse_start(16'h5A39);
        for (int n = 0; n < 100 && m_issued < NCHUNK; n++) step();
        step();
        start = 1'b1;
        password_in = 16'hFFFF;
        step();
        start = 1'b0;
        run_to_done(500, 0);
        chk("ign_password", 64'(eng_password), 64'h5A39);
        chk("ign_found", 64'(found), 64'd0);
        chk("ign_done", 64'(done), 64'd1);
        chk("ign_nstarts", 64'(log_eng.size()), 64'd5);

        // Reset during dispatch
        pulse_start(16'h1234);
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_from", 64'(eng_from), 64'd0);
        chk("rst_to", 64'(eng_to), 64'd0);
        chk("rst_password", 64'(eng_password), 64'd0);
        chk("rst_start", 64'(eng_start), 64'd0);
        rst = 1'b0;
        clear_logs();
        repeat (10) step();
        chk("rst_nstarts", 64'(log_eng.size()), 64'd0);

`ifdef CRACK_TIMEOUT_EN
        // Watchdog with engines that never finish
        set_lat(0, 0, 0, 0);
        hit_mask = '0;
        clear_logs();
        pulse_start(16'h2020);
        run_to_done(300, 0);
        chk("tmo_abort", 64'(last_abort), 64'(4'b1111));
        chk("tmo_cycle", 64'(abort_cyc - start_cyc), 64'(TB_TIMEOUT));
        chk("tmo_flag", 64'(timeout), 64'd1);
        chk("tmo_found", 64'(found), 64'd0);
        chk("tmo_done", 64'(done), 64'd1);
`endif

        // Randomised jobs
        spurious = 1;
        for (int j = 0; j < 40; j++) begin
            int r;
            for (int i = 0; i < NE; i++) lat[i] = $urandom_range(1, 24);
            hit_mask = '0;
            r = $urandom_range(0, 3);
            if (r >= 1) hit_mask[$urandom_range(0, NCHUNK - 1) * CH] = 1'b1;
            if (r >= 2) hit_mask[$urandom_range(0, NCHUNK - 1) * CH] = 1'b1;
            pulse_start(16'($urandom));
            run_to_done(2000, 1);
            repeat ($urandom_range(0, 4)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
